// File: rtl/conv_window_engine_pkg.sv
// Shared constants, FSM state type and the shift-then-saturate helper
// used by the convolution window engine.
package conv_pkg;
  localparam int TAPS   = 9;
  localparam int GROUP  = 4;
  localparam int ACC_W  = 20;
  localparam int PIX_W  = 8;
  localparam int TAP_W  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {ACCUM, BURST} state_t;

  function automatic logic signed [PIX_W-1:0] sat8(input logic signed [ACC_W-1:0] acc,
                                                   input int shift);
    logic signed [ACC_W-1:0] s;
    s = acc >>> shift;
    if (s > ACC_W'(127))
      return 8'sh7f;
    else if (s < -ACC_W'(128))
      return 8'sh80;
    else
      return s[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/conv_window_engine_if.sv
// Weight load, pixel stream and pooling-side result signals of the engine.
interface conv_window_engine_if;
  import conv_pkg::*;

  logic                    weight_wr;
  logic [3:0]              weight_addr;
  logic signed [PIX_W-1:0] weight_data;
  logic                    pix_valid;
  logic signed [PIX_W-1:0] pix_data;
  logic                    pix_ready;
  logic signed [PIX_W-1:0] conv_result;
  logic                    pool_en;
  logic                    busy;

  modport master (
    output weight_wr, weight_addr, weight_data, pix_valid, pix_data,
    input  pix_ready, conv_result, pool_en, busy
  );

  modport slave (
    input  weight_wr, weight_addr, weight_data, pix_valid, pix_data,
    output pix_ready, conv_result, pool_en, busy
  );
endinterface

// File: rtl/conv_window_engine_mac.sv
// Signed 8x8 multiply-accumulate over one window; result is the saturated
// final sum including the current product, valid on the last tap.
module conv_mac
  import conv_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    last,
  input  logic signed [PIX_W-1:0] pix,
  input  logic signed [PIX_W-1:0] wgt,
  output logic signed [PIX_W-1:0] result
);
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum;
  logic signed [2*PIX_W-1:0] prod;

  assign prod   = (2*PIX_W)'(pix) * (2*PIX_W)'(wgt);
  assign sum    = acc + ACC_W'(prod);
  assign result = sat8(sum, SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (en)
      acc <= last ? '0 : sum;
  end
endmodule

// File: rtl/conv_window_engine.sv
// 3x3 conv engine: accumulates 9 pixels per window, buffers 4 results, then
// bursts them on 4 cycles with pool_en on the last; pixels stall during the burst.
module conv_window_engine
  import conv_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_engine_if.slave cw
);
  logic signed [PIX_W-1:0] weight  [TAPS];
  logic signed [PIX_W-1:0] res_buf [GROUP];
  logic [TAP_W-1:0]        tap_cnt;
  logic [SLOT_W-1:0]       slot_cnt;
  logic [SLOT_W-1:0]       b_cnt;
  logic [SLOT_W-1:0]       b_nxt;
  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    last_tap;
  logic                    group_done;
  logic signed [PIX_W-1:0] mac_result;
  logic signed [PIX_W-1:0] result_q;
  logic                    pool_q;

  assign accept     = cw.pix_valid && (state == ACCUM);
  assign last_tap   = (tap_cnt == TAP_W'(TAPS-1));
  assign group_done = accept && last_tap && (slot_cnt == SLOT_W'(GROUP-1));

  conv_mac #(.SHIFT(SHIFT)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (accept),
    .last   (last_tap),
    .pix    (cw.pix_data),
    .wgt    (weight[tap_cnt]),
    .result (mac_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      b_cnt <= '0;
    end else begin
      state <= state_nxt;
      b_cnt <= b_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    b_nxt     = b_cnt;
    case (state)
      ACCUM: begin
        b_nxt = '0;
        if (group_done)
          state_nxt = BURST;
      end
      BURST: begin
        b_nxt = b_cnt + SLOT_W'(1);
        if (b_cnt == SLOT_W'(GROUP-1))
          state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Outputs are registered from the next-state view so buf[b] appears in burst cycle b.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt  <= '0;
      slot_cnt <= '0;
      result_q <= '0;
      pool_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++)
        weight[i] <= '0;
      for (int i = 0; i < GROUP; i++)
        res_buf[i] <= '0;
    end else begin
      if (cw.weight_wr && (cw.weight_addr < TAP_W'(TAPS)))
        weight[cw.weight_addr] <= cw.weight_data;
      if (accept) begin
        tap_cnt <= last_tap ? '0 : tap_cnt + TAP_W'(1);
        if (last_tap) begin
          res_buf[slot_cnt] <= mac_result;
          slot_cnt          <= slot_cnt + SLOT_W'(1);
        end
      end
      result_q <= (state_nxt == BURST) ? res_buf[b_nxt] : '0;
      pool_q   <= (state_nxt == BURST) && (b_nxt == SLOT_W'(GROUP-1));
    end
  end

  assign cw.pix_ready   = (state == ACCUM);
  assign cw.busy        = (state == BURST) || (tap_cnt != '0);
  assign cw.conv_result = result_q;
  assign cw.pool_en     = pool_q;
endmodule

// File: tb/tb_conv_window_engine.sv
// Bench for conv_window_engine: vector table, corner-case sequences and random
// traffic, all checked every cycle against a queue-based window/group model.
module tb_conv_window_engine;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_engine_if cw();
  conv_window_engine #(.SHIFT(0)) dut (.clk(clk), .rst(rst), .cw(cw));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer dot product per window, groups of four
  // results become a queue of expected (result, pool_en) cycles.
  logic signed [7:0] m_w [9];
  int                m_acc;
  int                m_taps;
  int                m_grp[$];
  int                m_out[$];
  logic [7:0]        seen[$];

  function automatic int sat(input int s);
    int v;
    v = s >>> 0;
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  always @(negedge clk) begin
    int e;
    bit burst;
    if (rst) begin
      for (int i = 0; i < 9; i++) m_w[i] = '0;
      m_acc  = 0;
      m_taps = 0;
      m_grp.delete();
      m_out.delete();
      check("rst_result", int'($unsigned(cw.conv_result)), 0);
      check("rst_pool_en", int'(cw.pool_en), 0);
      check("rst_ready", int'(cw.pix_ready), 1);
      check("rst_busy", int'(cw.busy), 0);
    end else begin
      burst = (m_out.size() != 0);
      e = burst ? m_out.pop_front() : 0;
      check("conv_result", int'($unsigned(cw.conv_result)), e & 255);
      check("pool_en", int'(cw.pool_en), e >> 8);
      check("pix_ready", int'(cw.pix_ready), burst ? 0 : 1);
      check("busy", int'(cw.busy), (burst || m_taps != 0) ? 1 : 0);
      if (!cw.pix_ready) seen.push_back(cw.conv_result);
      if (cw.pix_valid && !burst) begin
        m_acc += int'(cw.pix_data) * int'(m_w[m_taps]);
        m_taps++;
        if (m_taps == TAPS) begin
          m_grp.push_back(sat(m_acc));
          m_acc  = 0;
          m_taps = 0;
          if (m_grp.size() == GROUP) begin
            for (int i = 0; i < GROUP; i++)
              m_out.push_back((m_grp[i] & 255) | ((i == GROUP-1) ? 256 : 0));
            m_grp.delete();
          end
        end
      end
      if (cw.weight_wr && cw.weight_addr < 4'd9) m_w[cw.weight_addr] = cw.weight_data;
    end
  end

  task automatic write_weight(input logic [3:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    cw.weight_wr   = 1'b1;
    cw.weight_addr = addr;
    cw.weight_data = data;
    @(posedge clk); #1;
    cw.weight_wr   = 1'b0;
  endtask

  task automatic load_weights(input logic [8:0][7:0] w);
    for (int t = 0; t < 9; t++) begin
      @(posedge clk); #1;
      cw.weight_wr   = 1'b1;
      cw.weight_addr = 4'(t);
      cw.weight_data = w[t];
    end
    @(posedge clk); #1;
    cw.weight_wr = 1'b0;
  endtask

  task automatic stream(input logic [7:0] px[$], output int cycles);
    int  i = 0;
    bit  took;
    cycles = 0;
    @(posedge clk); #1;
    while (i < px.size() && cycles < 500) begin
      cw.pix_valid = 1'b1;
      cw.pix_data  = px[i];
      @(negedge clk);
      took = cw.pix_ready;
      @(posedge clk); #1;
      if (took) i++;
      cycles++;
    end
    cw.pix_valid = 1'b0;
    check("stream_done", i, px.size());
  endtask

  task automatic wait_seen(input int n, input string name);
    int k = 0;
    while (seen.size() < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, seen.size(), n);
  endtask

  typedef struct packed {
    logic [8:0][7:0] wgt;
    logic [3:0][7:0] pix;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] px[$];
    int cyc;
    int k;

    rst = 1'b1;
    cw.weight_wr = 1'b0; cw.weight_addr = '0; cw.weight_data = '0;
    cw.pix_valid = 1'b0; cw.pix_data = '0;

    vecs[0] = '{wgt: {9{8'h01}}, pix: {4{8'h01}}, exp: {4{8'h09}}};
    vecs[1] = '{wgt: {9{8'h7F}}, pix: {4{8'h7F}}, exp: {4{8'h7F}}};
    vecs[2] = '{wgt: {9{8'hFF}}, pix: {4{8'h64}}, exp: {4{8'h80}}};
    vecs[3] = '{wgt: {{8{8'h00}}, 8'h01}, pix: {8'h03, 8'h02, 8'hFD, 8'h05},
                exp: {8'h03, 8'h02, 8'hFD, 8'h05}};
    vecs[4] = '{wgt: {9{8'h02}}, pix: {8'h00, 8'h07, 8'hFE, 8'h03},
                exp: {8'h00, 8'h7E, 8'hDC, 8'h36}};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_weights(vecs[v].wgt);
      seen.delete();
      px.delete();
      for (int w = 0; w < GROUP; w++)
        for (int t = 0; t < TAPS; t++) px.push_back(vecs[v].pix[w]);
      stream(px, cyc);
      check($sformatf("vec%0d_cycles", v), cyc, 36);
      wait_seen(4, $sformatf("vec%0d_burst_len", v));
      for (int i = 0; i < GROUP; i++)
        check($sformatf("vec%0d_res%0d", v, i), int'(seen[i]), int'(vecs[v].exp[i]));
    end

    // Valid held across the burst while tap 0 is rewritten mid-burst.
    load_weights({9{8'h01}});
    seen.delete();
    px.delete();
    for (int i = 0; i < 36; i++) px.push_back(8'h01);
    for (int i = 0; i < 36; i++) px.push_back(8'h02);
    fork
      stream(px, cyc);
      begin
        k = 0;
        while (cw.pix_ready && k < 200) begin
          @(negedge clk); #1;
          k++;
        end
        check("hold_burst_entered", int'(cw.pix_ready), 0);
        @(posedge clk); #1;
        cw.weight_wr = 1'b1; cw.weight_addr = 4'd0; cw.weight_data = 8'h05;
        @(posedge clk); #1;
        cw.weight_wr = 1'b0;
      end
    join
    check("hold_cycles", cyc, 76);
    wait_seen(8, "hold_burst_len");
    for (int i = 0; i < 8; i++)
      check($sformatf("hold_res%0d", i), int'(seen[i]), (i < 4) ? 8'h09 : 8'h1A);

    // Reset mid-window; afterwards only tap 0 is loaded, so stale weights would show.
    load_weights({9{8'h03}});
    px.delete();
    for (int i = 0; i < 20; i++) px.push_back(8'h01);
    stream(px, cyc);
    check("pre_rst_busy", int'(cw.busy), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("in_rst_result", int'($unsigned(cw.conv_result)), 0);
    check("in_rst_busy", int'(cw.busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    write_weight(4'd0, 8'h01);
    write_weight(4'd9, 8'h55);
    write_weight(4'd12, 8'h55);
    seen.delete();
    px.delete();
    for (int i = 0; i < 36; i++) px.push_back(8'h04);
    stream(px, cyc);
    wait_seen(4, "post_rst_burst_len");
    for (int i = 0; i < 4; i++)
      check($sformatf("post_rst_res%0d", i), int'(seen[i]), 4);

    // Reset while pool_en is high must drop it without waiting for a clock.
    px.delete();
    for (int i = 0; i < 36; i++) px.push_back(8'h07);
    stream(px, cyc);
    k = 0;
    while (!cw.pool_en && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check("pool_en_seen", int'(cw.pool_en), 1);
    check("pool_en_result", int'($unsigned(cw.conv_result)), 7);
    #1 rst = 1'b1;
    #1;
    check("async_pool_en", int'(cw.pool_en), 0);
    check("async_result", int'($unsigned(cw.conv_result)), 0);
    check("async_ready", int'(cw.pix_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic: valid gaps, pixels held during bursts, random weight writes.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      cw.pix_valid   = ($urandom_range(0, 3) != 0);
      cw.pix_data    = ($urandom_range(0, 1) != 0) ? 8'($urandom)
                                                   : 8'($urandom_range(0, 16)) - 8'd8;
      cw.weight_wr   = ($urandom_range(0, 9) == 0);
      cw.weight_addr = 4'($urandom);
      cw.weight_data = ($urandom_range(0, 1) != 0) ? 8'($urandom)
                                                   : 8'($urandom_range(0, 6)) - 8'd3;
    end
    @(posedge clk); #1;
    cw.pix_valid = 1'b0;
    cw.weight_wr = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
